// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: opcodes, ALU selects and sequencer states.
// Imported by the sequencer, its decoder and the datapath.
package cpu_pkg;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_NAND  = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_BEQ   = 4'hD;
  localparam logic [3:0] OP_BNE   = 4'hE;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NAND = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_SHR  = 4'd7;

  typedef enum logic [3:0] {
    S_INIT   = 4'h0,
    S_FETCH  = 4'h1,
    S_DECODE = 4'h2,
    S_LOAD_A = 4'h3,
    S_LOAD_B = 4'h4,
    S_STORE  = 4'h5,
    S_ALU    = 4'h6,
    S_BRANCH = 4'h7,
    S_JMP    = 4'h8,
    S_HALT   = 4'h9,
    S_NOOP   = 4'hA,
    S_TRAP   = 4'hB
  } state_e;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath/memory bundle.
// master = control sequencer, slave = datapath side.
interface control_sequencer_if #(
  parameter int RAW = 4
);
  localparam int IW  = 4 + 3*RAW;
  localparam int DAW = 2*RAW;

  logic [IW-1:0]  IR;
  logic           I_RDY;
  logic           D_RDY;
  logic           ALU_Z;
  logic           PC_CLR;
  logic           PC_IC;
  logic           PC_LD;
  logic           PC_REL;
  logic [DAW-1:0] PC_VAL;
  logic           IR_LD;
  logic [DAW-1:0] D_ADDR;
  logic           D_RD;
  logic           D_WR;
  logic           RF_S;
  logic           RF_W_EN;
  logic [RAW-1:0] RF_A_ADDR;
  logic [RAW-1:0] RF_B_ADDR;
  logic [RAW-1:0] RF_W_ADDR;
  logic [3:0]     ALU_S;
  logic           HALTED;
  logic           TRAP;
  logic [3:0]     STATE;

  modport master (
    input  IR, I_RDY, D_RDY, ALU_Z,
    output PC_CLR, PC_IC, PC_LD, PC_REL,
    output PC_VAL, IR_LD, D_ADDR, D_RD,
    output D_WR, RF_S, RF_W_EN,
    output RF_A_ADDR, RF_B_ADDR, RF_W_ADDR,
    output ALU_S, HALTED, TRAP, STATE
  );

  modport slave (
    output IR, I_RDY, D_RDY, ALU_Z,
    input  PC_CLR, PC_IC, PC_LD, PC_REL,
    input  PC_VAL, IR_LD, D_ADDR, D_RD,
    input  D_WR, RF_S, RF_W_EN,
    input  RF_A_ADDR, RF_B_ADDR, RF_W_ADDR,
    input  ALU_S, HALTED, TRAP, STATE
  );

endinterface

// File: rtl/cu_decode.sv
// Opcode -> post-DECODE state and ALU function select.
// CU_BRANCH_EN enables JMP/BEQ/BNE; otherwise they trap.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op_i,
  output state_e     state_o,
  output logic [3:0] alu_s_o
);

  always_comb begin
    state_o = S_TRAP;
    alu_s_o = ALU_ADD;
    unique case (1'b1)
      (op_i == OP_NOOP):  state_o = S_NOOP;
      (op_i == OP_STORE): state_o = S_STORE;
      (op_i == OP_LOAD):  state_o = S_LOAD_A;
      (op_i == OP_HALT):  state_o = S_HALT;
      (op_i == OP_ADD):   state_o = S_ALU;
      (op_i == OP_SUB): begin
        state_o = S_ALU;
        alu_s_o = ALU_SUB;
      end
      (op_i == OP_AND): begin
        state_o = S_ALU;
        alu_s_o = ALU_AND;
      end
      (op_i == OP_OR): begin
        state_o = S_ALU;
        alu_s_o = ALU_OR;
      end
      (op_i == OP_XOR): begin
        state_o = S_ALU;
        alu_s_o = ALU_XOR;
      end
      (op_i == OP_NAND): begin
        state_o = S_ALU;
        alu_s_o = ALU_NAND;
      end
      (op_i == OP_SHL): begin
        state_o = S_ALU;
        alu_s_o = ALU_SHL;
      end
      (op_i == OP_SHR): begin
        state_o = S_ALU;
        alu_s_o = ALU_SHR;
      end
`ifdef CU_BRANCH_EN
      (op_i == OP_JMP):   state_o = S_JMP;
      (op_i == OP_BEQ),
      (op_i == OP_BNE):   state_o = S_BRANCH;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control sequencer for the 16-bit CPU datapath.
// Define CU_BRANCH_EN to build the JMP/BEQ/BNE states.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int RAW = 4
) (
  input logic                 Clock,
  input logic                 Reset,
  control_sequencer_if.master bus
);

  localparam int IW  = 4 + 3*RAW;
  localparam int DAW = 2*RAW;

  logic [3:0]     op;
  logic [RAW-1:0] fa, fb, fc;
  state_e         state_q, state_d, dec_state;
  logic [3:0]     dec_alu;

  assign op = bus.IR[IW-1 -: 4];
  assign fa = bus.IR[3*RAW-1 -: RAW];
  assign fb = bus.IR[2*RAW-1 -: RAW];
  assign fc = bus.IR[RAW-1:0];

  cu_decode u_dec (
    .op_i    (op),
    .state_o (dec_state),
    .alu_s_o (dec_alu)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  if (bus.I_RDY) state_d = S_DECODE;
      S_DECODE: state_d = dec_state;
      S_LOAD_A: if (bus.D_RDY) state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  if (bus.D_RDY) state_d = S_FETCH;
      S_ALU:    state_d = S_FETCH;
      S_NOOP:   state_d = S_FETCH;
`ifdef CU_BRANCH_EN
      S_BRANCH: state_d = S_FETCH;
      S_JMP:    state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  logic       clr, ic, irld, drd, dwr, wen, rf_s;
  logic [3:0] alu_s;
`ifdef CU_BRANCH_EN
  logic           ld, rel;
  logic [DAW-1:0] pc_val;
`endif

  always_comb begin
    clr   = 1'b0;
    ic    = 1'b0;
    irld  = 1'b0;
    drd   = 1'b0;
    dwr   = 1'b0;
    wen   = 1'b0;
    rf_s  = 1'b0;
    alu_s = ALU_ADD;
`ifdef CU_BRANCH_EN
    ld     = 1'b0;
    rel    = 1'b0;
    pc_val = '0;
`endif
    unique case (state_q)
      S_INIT:   clr  = 1'b1;
      S_FETCH:  irld = bus.I_RDY;
      S_DECODE: ic   = 1'b1;
      S_LOAD_A: begin
        drd  = 1'b1;
        rf_s = 1'b1;
      end
      S_LOAD_B: begin
        rf_s = 1'b1;
        wen  = 1'b1;
      end
      S_STORE:  dwr = 1'b1;
      S_ALU: begin
        wen   = 1'b1;
        alu_s = dec_alu;
      end
`ifdef CU_BRANCH_EN
      // Offset is relative to the already-incremented PC.
      S_BRANCH: begin
        alu_s  = ALU_SUB;
        pc_val = {{(DAW-RAW){fc[RAW-1]}}, fc};
        rel    = (op == OP_BEQ) ? bus.ALU_Z : !bus.ALU_Z;
      end
      S_JMP: begin
        ld     = 1'b1;
        pc_val = {fb, fc};
      end
`endif
      default: ;
    endcase
  end

  assign bus.PC_CLR  = clr  & ~Reset;
  assign bus.PC_IC   = ic   & ~Reset;
  assign bus.IR_LD   = irld & ~Reset;
  assign bus.D_RD    = drd  & ~Reset;
  assign bus.D_WR    = dwr  & ~Reset;
  assign bus.RF_W_EN = wen  & ~Reset;
`ifdef CU_BRANCH_EN
  assign bus.PC_LD   = ld   & ~Reset;
  assign bus.PC_REL  = rel  & ~Reset;
  assign bus.PC_VAL  = pc_val;
`else
  logic unused_alu_z;
  assign unused_alu_z = bus.ALU_Z;
  assign bus.PC_LD    = 1'b0;
  assign bus.PC_REL   = 1'b0;
  assign bus.PC_VAL   = '0;
`endif

  assign bus.RF_S      = rf_s;
  assign bus.ALU_S     = alu_s;
  assign bus.RF_A_ADDR = fa;
  assign bus.RF_B_ADDR = fb;
  assign bus.RF_W_ADDR = fc;
  assign bus.D_ADDR    = (state_q == S_STORE) ? {fb, fc} : {fa, fb};
  assign bus.HALTED    = (state_q == S_HALT);
  assign bus.TRAP      = (state_q == S_TRAP);
  assign bus.STATE     = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: driver queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_control_sequencer;

  typedef struct packed {
    logic [3:0] st;
    logic [8:0] sb;
    logic [3:0] alu;
    logic [7:0] da;
    logic [7:0] pcv;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rw;
    logic       hl;
    logic       tr;
  } obs_t;

  localparam logic [8:0] NONE = 9'h000;
  localparam logic [8:0] CLR  = 9'h100;
  localparam logic [8:0] IC   = 9'h080;
  localparam logic [8:0] LD   = 9'h040;
  localparam logic [8:0] REL  = 9'h020;
  localparam logic [8:0] IRL  = 9'h010;
  localparam logic [8:0] DRD  = 9'h008;
  localparam logic [8:0] DWR  = 9'h004;
  localparam logic [8:0] WEN  = 9'h002;
  localparam logic [8:0] RFS  = 9'h001;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  control_sequencer_if #(.RAW(4)) bus();

  control_sequencer #(.RAW(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  obs_t  exp_q[$];
  string nm_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  logic [3:0] c_ra, c_rb, c_rw;
  logic [7:0] c_da, c_das;

  task automatic set_ir(input logic [15:0] ir,
                        input logic [3:0] ra, rb, rw,
                        input logic [7:0] da, das);
    bus.IR = ir;
    c_ra = ra;
    c_rb = rb;
    c_rw = rw;
    c_da = da;
    c_das = das;
  endtask

  task automatic chk(input string nm, input logic [3:0] st,
                     input logic [8:0] sb, input logic [3:0] alu,
                     input logic [7:0] pcv, input logic hl, tr);
    obs_t e;
    e.st  = st;
    e.sb  = sb;
    e.alu = alu;
    e.da  = (st == 4'h5) ? c_das : c_da;
    e.pcv = pcv;
    e.ra  = c_ra;
    e.rb  = c_rb;
    e.rw  = c_rw;
    e.hl  = hl;
    e.tr  = tr;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge Clock);
    #1;
  endtask

  task automatic fd();
    chk("fetch", 4'h1, IRL, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("decode", 4'h2, IC, 4'h0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic alu_op(input string nm, input logic [15:0] ir,
                        input logic [3:0] ra, rb, rw,
                        input logic [7:0] da, das,
                        input logic [3:0] alu);
    set_ir(ir, ra, rb, rw, da, das);
    fd();
    chk(nm, 4'h6, WEN, alu, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic [3:0] st, input logic hl, tr);
    Reset = 1'b1;
    chk("rst_hold", st, NONE, 4'h0, 8'h00, hl, tr);
    Reset = 1'b0;
    chk("rst_init", 4'h0, CLR, 4'h0, 8'h00, 1'b0, 1'b0);
  endtask

  always @(negedge Clock) begin
    obs_t  a, e;
    string nm;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      nm = nm_q.pop_front();
      a.st  = bus.STATE;
      a.sb  = {bus.PC_CLR, bus.PC_IC, bus.PC_LD, bus.PC_REL,
               bus.IR_LD, bus.D_RD, bus.D_WR, bus.RF_W_EN,
               bus.RF_S};
      a.alu = bus.ALU_S;
      a.da  = bus.D_ADDR;
      a.pcv = bus.PC_VAL;
      a.ra  = bus.RF_A_ADDR;
      a.rb  = bus.RF_B_ADDR;
      a.rw  = bus.RF_W_ADDR;
      a.hl  = bus.HALTED;
      a.tr  = bus.TRAP;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s @%0t: got st=%h sb=%b alu=%h da=%h pv=%h r=%h%h%h h=%b t=%b want st=%h sb=%b alu=%h da=%h pv=%h r=%h%h%h h=%b t=%b",
                 nm, $time, a.st, a.sb, a.alu, a.da, a.pcv,
                 a.ra, a.rb, a.rw, a.hl, a.tr,
                 e.st, e.sb, e.alu, e.da, e.pcv,
                 e.ra, e.rb, e.rw, e.hl, e.tr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    bus.I_RDY = 1'b0;
    bus.D_RDY = 1'b0;
    bus.ALU_Z = 1'b0;
    set_ir(16'h3125, 4'h1, 4'h2, 4'h5, 8'h12, 8'h25);
    @(posedge Clock);
    #1;
    chk("rst1", 4'h0, NONE, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("rst2", 4'h0, NONE, 4'h0, 8'h00, 1'b0, 1'b0);
    Reset = 1'b0;
    chk("init_clr", 4'h0, CLR, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("fetch_wait", 4'h1, NONE, 4'h0, 8'h00, 1'b0, 1'b0);
    bus.I_RDY = 1'b1;
    fd();
    chk("add", 4'h6, WEN, 4'h0, 8'h00, 1'b0, 1'b0);

    alu_op("sub", 16'h4321, 4'h3, 4'h2, 4'h1, 8'h32, 8'h21, 4'h1);
    alu_op("nand", 16'h9ABC, 4'hA, 4'hB, 4'hC, 8'hAB, 8'hBC, 4'h5);
    alu_op("shr", 16'hB456, 4'h4, 4'h5, 4'h6, 8'h45, 8'h56, 4'h7);

    set_ir(16'h0123, 4'h1, 4'h2, 4'h3, 8'h12, 8'h23);
    fd();
    chk("noop", 4'hA, NONE, 4'h0, 8'h00, 1'b0, 1'b0);

    set_ir(16'h2A37, 4'hA, 4'h3, 4'h7, 8'hA3, 8'h37);
    fd();
    chk("load_a1", 4'h3, DRD | RFS, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("load_a2", 4'h3, DRD | RFS, 4'h0, 8'h00, 1'b0, 1'b0);
    bus.D_RDY = 1'b1;
    chk("load_a3", 4'h3, DRD | RFS, 4'h0, 8'h00, 1'b0, 1'b0);
    bus.D_RDY = 1'b0;
    chk("load_b", 4'h4, WEN | RFS, 4'h0, 8'h00, 1'b0, 1'b0);

    set_ir(16'h14C8, 4'h4, 4'hC, 4'h8, 8'h4C, 8'hC8);
    fd();
    repeat (3) chk("store_w", 4'h5, DWR, 4'h0, 8'h00, 1'b0, 1'b0);
    bus.D_RDY = 1'b1;
    chk("store_d", 4'h5, DWR, 4'h0, 8'h00, 1'b0, 1'b0);
    bus.D_RDY = 1'b0;

`ifdef CU_BRANCH_EN
    bus.ALU_Z = 1'b1;
    set_ir(16'hD12E, 4'h1, 4'h2, 4'hE, 8'h12, 8'h2E);
    fd();
    chk("beq_t", 4'h7, REL, 4'h1, 8'hFE, 1'b0, 1'b0);
    set_ir(16'hE12E, 4'h1, 4'h2, 4'hE, 8'h12, 8'h2E);
    fd();
    chk("bne_nt", 4'h7, NONE, 4'h1, 8'hFE, 1'b0, 1'b0);
    bus.ALU_Z = 1'b0;
    fd();
    chk("bne_t", 4'h7, REL, 4'h1, 8'hFE, 1'b0, 1'b0);
    set_ir(16'hD12E, 4'h1, 4'h2, 4'hE, 8'h12, 8'h2E);
    fd();
    chk("beq_nt", 4'h7, NONE, 4'h1, 8'hFE, 1'b0, 1'b0);
    set_ir(16'hC0A5, 4'h0, 4'hA, 4'h5, 8'h0A, 8'hA5);
    fd();
    chk("jmp", 4'h8, LD, 4'h0, 8'hA5, 1'b0, 1'b0);
`else
    bus.ALU_Z = 1'b1;
    set_ir(16'hD12E, 4'h1, 4'h2, 4'hE, 8'h12, 8'h2E);
    fd();
    chk("beq_trap", 4'hB, NONE, 4'h0, 8'h00, 1'b0, 1'b1);
    do_reset(4'hB, 1'b0, 1'b1);
    set_ir(16'hC0A5, 4'h0, 4'hA, 4'h5, 8'h0A, 8'hA5);
    chk("fetch_wait2", 4'h0 + 4'h1, IRL, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("decode2", 4'h2, IC, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("jmp_trap", 4'hB, NONE, 4'h0, 8'h00, 1'b0, 1'b1);
    do_reset(4'hB, 1'b0, 1'b1);
    bus.ALU_Z = 1'b0;
`endif

    set_ir(16'h14C8, 4'h4, 4'hC, 4'h8, 8'h4C, 8'hC8);
    fd();
    chk("store_mid", 4'h5, DWR, 4'h0, 8'h00, 1'b0, 1'b0);
    do_reset(4'h5, 1'b0, 1'b0);

    set_ir(16'h5000, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
    fd();
    repeat (10) chk("halt", 4'h9, NONE, 4'h0, 8'h00, 1'b1, 1'b0);
    do_reset(4'h9, 1'b1, 1'b0);

    set_ir(16'hF000, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
    fd();
    repeat (2) chk("trap", 4'hB, NONE, 4'h0, 8'h00, 1'b0, 1'b1);
    do_reset(4'hB, 1'b0, 1'b1);

    alu_op("add2", 16'h3125, 4'h1, 4'h2, 4'h5, 8'h12, 8'h25, 4'h0);

    @(negedge Clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
